// File: rtl/histogram_pkg.sv
// Shared types and constants for the histogram compressor/decompressor pair.
// Bin indices follow {stream_a, stream_b} order.
package histogram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2
  } hc_state_t;

  localparam logic [1:0] BIN_00 = 2'b00;
  localparam logic [1:0] BIN_01 = 2'b01;
  localparam logic [1:0] BIN_10 = 2'b10;
  localparam logic [1:0] BIN_11 = 2'b11;

  localparam int NUM_BINS = 4;

  function automatic int hist_cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/histogram_compressor_bin_counter.sv
// Up-counter with synchronous clear and increment enable.
// Used for each histogram bin and for the window sample count.
module histogram_bin_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Clear has priority so a new window never inherits a stale increment.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/histogram_compressor.sv
// Counts {stream_a, stream_b} pair occurrences over a window and hands the
// four bin counts to the consumer through a single-entry valid/ack register.
//
// state | meaning
// IDLE  | no window open; waiting for start_compress
// ACCUM | accepting samples into the bin accumulators
// FLUSH | window closed, counts frozen, waiting for the output slot to free
module histogram_compressor
  import histogram_pkg::*;
#(
  parameter int STREAM_LENGTH = 128,
  parameter int COUNTER_WIDTH = hist_cnt_width(STREAM_LENGTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_compress,
  input  logic                     valid_in,
  input  logic                     stream_a,
  input  logic                     stream_b,
  input  logic                     end_window,
  output logic                     in_ready,
  output logic                     busy,
  output logic [COUNTER_WIDTH-1:0] count_00,
  output logic [COUNTER_WIDTH-1:0] count_01,
  output logic [COUNTER_WIDTH-1:0] count_10,
  output logic [COUNTER_WIDTH-1:0] count_11,
  output logic [COUNTER_WIDTH-1:0] window_len,
  output logic                     counts_valid,
  input  logic                     counts_ack
);

  localparam logic [COUNTER_WIDTH-1:0] LEN_MAX = COUNTER_WIDTH'(STREAM_LENGTH);

  hc_state_t state_q;
  hc_state_t state_d;

  logic [COUNTER_WIDTH-1:0] bin_cnt  [NUM_BINS];
  logic [COUNTER_WIDTH-1:0] bin_next [NUM_BINS];
  logic [COUNTER_WIDTH-1:0] samp_cnt;
  logic [COUNTER_WIDTH-1:0] samp_next;

  logic [COUNTER_WIDTH-1:0] cnt_out_q [NUM_BINS];
  logic [COUNTER_WIDTH-1:0] cnt_out_d [NUM_BINS];
  logic [COUNTER_WIDTH-1:0] len_q;
  logic [COUNTER_WIDTH-1:0] len_d;
  logic                     counts_valid_q;
  logic                     counts_valid_d;

  logic [1:0] bin_sel;
  logic       accept;
  logic       acc_clr;
  logic       hit_full;
  logic       close_win;
  logic       slot_free;
  logic       load;

  assign bin_sel   = {stream_a, stream_b};
  assign accept    = valid_in && in_ready;
  assign acc_clr   = (state_q == IDLE) && start_compress;
  assign samp_next = samp_cnt + COUNTER_WIDTH'(accept);
  assign hit_full  = accept && (samp_next == LEN_MAX);
  assign close_win = (state_q == ACCUM) && (end_window || hit_full);
  assign slot_free = !counts_valid_q || counts_ack;

  for (genvar b = 0; b < NUM_BINS; b++) begin : g_bin
    histogram_bin_counter #(
      .WIDTH (COUNTER_WIDTH)
    ) u_bin (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (acc_clr),
      .inc   (accept && (bin_sel == 2'(b))),
      .count (bin_cnt[b])
    );
  end

  histogram_bin_counter #(
    .WIDTH (COUNTER_WIDTH)
  ) u_samp (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .inc   (accept),
    .count (samp_cnt)
  );

  // Next-cycle accumulator values, so a closing-cycle sample lands in the load.
  // In FLUSH nothing is accepted, so these equal the frozen accumulators.
  always_comb begin
    for (int b = 0; b < NUM_BINS; b++) begin
      bin_next[b] = bin_cnt[b] + COUNTER_WIDTH'(accept && (bin_sel == 2'(b)));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_compress) state_d = ACCUM;
      ACCUM:   if (close_win)      state_d = slot_free ? IDLE : FLUSH;
      FLUSH:   if (slot_free)      state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    load     = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        load     = close_win && slot_free;
      end
      FLUSH: begin
        busy = 1'b1;
        load = slot_free;
      end
      default: ;
    endcase
  end

  // A load in the same cycle as an ack keeps counts_valid high.
  always_comb begin
    for (int b = 0; b < NUM_BINS; b++) begin
      cnt_out_d[b] = cnt_out_q[b];
    end
    len_d          = len_q;
    counts_valid_d = counts_valid_q;
    if (load) begin
      for (int b = 0; b < NUM_BINS; b++) begin
        cnt_out_d[b] = bin_next[b];
      end
      len_d          = samp_next;
      counts_valid_d = 1'b1;
    end else if (counts_valid_q && counts_ack) begin
      counts_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BINS; b++) begin
        cnt_out_q[b] <= '0;
      end
      len_q          <= '0;
      counts_valid_q <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BINS; b++) begin
        cnt_out_q[b] <= cnt_out_d[b];
      end
      len_q          <= len_d;
      counts_valid_q <= counts_valid_d;
    end
  end

  assign count_00     = cnt_out_q[BIN_00];
  assign count_01     = cnt_out_q[BIN_01];
  assign count_10     = cnt_out_q[BIN_10];
  assign count_11     = cnt_out_q[BIN_11];
  assign window_len   = len_q;
  assign counts_valid = counts_valid_q;

endmodule

// File: tb/tb_histogram_compressor.sv
// Self-checking bench for histogram_compressor: directed vector table,
// hand-written corner sequences, and random traffic against a reference model.
module tb_histogram_compressor;
  import histogram_pkg::*;

  localparam int SL = 128;
  localparam int CW = hist_cnt_width(SL);

  logic          clk;
  logic          rst_n;
  logic          start_compress;
  logic          valid_in;
  logic          stream_a;
  logic          stream_b;
  logic          end_window;
  logic          in_ready;
  logic          busy;
  logic [CW-1:0] count_00;
  logic [CW-1:0] count_01;
  logic [CW-1:0] count_10;
  logic [CW-1:0] count_11;
  logic [CW-1:0] window_len;
  logic          counts_valid;
  logic          counts_ack;

  histogram_compressor #(
    .STREAM_LENGTH (SL)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_compress (start_compress),
    .valid_in       (valid_in),
    .stream_a       (stream_a),
    .stream_b       (stream_b),
    .end_window     (end_window),
    .in_ready       (in_ready),
    .busy           (busy),
    .count_00       (count_00),
    .count_01       (count_01),
    .count_10       (count_10),
    .count_11       (count_11),
    .window_len     (window_len),
    .counts_valid   (counts_valid),
    .counts_ack     (counts_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: window phase (0 closed, 1 open, 2 closed but pending),
  // running bin tallies of the open window, and the held histogram.
  int m_phase = 0;
  int m_acc[4];
  int m_n = 0;
  int m_out[4];
  int m_len = 0;
  int m_valid = 0;

  task automatic model_step();
    bit take;
    bit free;
    int nv;
    if (!rst_n) begin
      m_phase = 0; m_n = 0; m_len = 0; m_valid = 0;
      for (int i = 0; i < 4; i++) begin m_acc[i] = 0; m_out[i] = 0; end
      return;
    end
    take = valid_in && (m_phase == 1);
    free = !m_valid || counts_ack;
    nv   = (m_valid && !counts_ack) ? 1 : 0;
    if (m_phase == 0) begin
      if (start_compress) begin
        for (int i = 0; i < 4; i++) m_acc[i] = 0;
        m_n = 0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (take) begin
        m_acc[stream_a * 2 + stream_b]++;
        m_n++;
      end
      if (end_window || (take && m_n == SL)) m_phase = 2;
    end
    if (m_phase == 2 && free) begin
      for (int i = 0; i < 4; i++) m_out[i] = m_acc[i];
      m_len = m_n;
      nv = 1;
      m_phase = 0;
    end
    m_valid = nv;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " in_ready"},     in_ready,     (m_phase == 1) ? 1 : 0);
    chk({tag, " busy"},         busy,         (m_phase != 0) ? 1 : 0);
    chk({tag, " counts_valid"}, counts_valid, m_valid);
    chk({tag, " count_00"},     count_00,     m_out[0]);
    chk({tag, " count_01"},     count_01,     m_out[1]);
    chk({tag, " count_10"},     count_10,     m_out[2]);
    chk({tag, " count_11"},     count_11,     m_out[3]);
    chk({tag, " window_len"},   window_len,   m_len);
  endtask

  task automatic idle_inputs();
    rst_n = 1'b1; start_compress = 1'b0; valid_in = 1'b0;
    stream_a = 1'b0; stream_b = 1'b0; end_window = 1'b0; counts_ack = 1'b0;
  endtask

  task automatic do_start();
    start_compress = 1'b1;
    cycle();
    check_model("start");
    start_compress = 1'b0;
  endtask

  task automatic do_ack();
    counts_ack = 1'b1;
    cycle();
    check_model("ack");
    counts_ack = 1'b0;
  endtask

  typedef struct {
    bit rst_n, start, vin, a, b, endw, ack;
    bit e_rdy, e_vld;
    int e00, e01, e10, e11, elen;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int pat[$];
    int acc;
    idle_inputs();
    rst_n = 1'b0;

    tbl[0]  = '{0,0,0,0,0,0,0, 0,0, 0,0,0,0,0};
    tbl[1]  = '{1,1,0,0,0,0,0, 1,0, 0,0,0,0,0};
    for (int i = 2; i <= 6; i++)
      tbl[i] = '{1,0,1,0,1,0,0, 1,0, 0,0,0,0,0};
    tbl[7]  = '{1,0,1,1,0,1,0, 0,1, 0,5,1,0,6};
    tbl[8]  = '{1,0,0,0,0,0,0, 0,1, 0,5,1,0,6};
    tbl[9]  = '{1,0,0,0,0,0,1, 0,0, 0,5,1,0,6};
    tbl[10] = '{1,1,0,0,0,0,0, 1,0, 0,5,1,0,6};
    tbl[11] = '{1,0,0,0,0,1,0, 0,1, 0,0,0,0,0};
    tbl[12] = '{1,1,0,0,0,0,1, 1,0, 0,0,0,0,0};
    tbl[13] = '{1,1,1,1,1,0,0, 1,0, 0,0,0,0,0};
    tbl[14] = '{1,0,1,0,0,1,0, 0,1, 1,0,0,1,2};
    tbl[15] = '{1,0,1,0,0,1,0, 0,1, 1,0,0,1,2};

    for (int i = 0; i < 16; i++) begin
      rst_n = tbl[i].rst_n; start_compress = tbl[i].start; valid_in = tbl[i].vin;
      stream_a = tbl[i].a; stream_b = tbl[i].b; end_window = tbl[i].endw;
      counts_ack = tbl[i].ack;
      cycle();
      chk($sformatf("vec%0d in_ready", i),     in_ready,     tbl[i].e_rdy);
      chk($sformatf("vec%0d counts_valid", i), counts_valid, tbl[i].e_vld);
      chk($sformatf("vec%0d count_00", i),     count_00,     tbl[i].e00);
      chk($sformatf("vec%0d count_01", i),     count_01,     tbl[i].e01);
      chk($sformatf("vec%0d count_10", i),     count_10,     tbl[i].e10);
      chk($sformatf("vec%0d count_11", i),     count_11,     tbl[i].e11);
      chk($sformatf("vec%0d window_len", i),   window_len,   tbl[i].elen);
      check_model($sformatf("vec%0d model", i));
    end
    idle_inputs();

    // Full window 40/30/20/38 in shuffled order, continuous valid.
    do_ack();
    for (int i = 0; i < 40; i++) pat.push_back(0);
    for (int i = 0; i < 30; i++) pat.push_back(1);
    for (int i = 0; i < 20; i++) pat.push_back(2);
    for (int i = 0; i < 38; i++) pat.push_back(3);
    for (int i = SL - 1; i > 0; i--) begin
      int j, t;
      j = $urandom_range(i, 0);
      t = pat[i]; pat[i] = pat[j]; pat[j] = t;
    end
    do_start();
    for (int i = 0; i < SL; i++) begin
      valid_in = 1'b1; stream_a = pat[i][1]; stream_b = pat[i][0];
      cycle();
      check_model("full");
      if (i < SL - 1) chk("full early valid", counts_valid, 0);
    end
    idle_inputs();
    chk("full valid",    counts_valid, 1);
    chk("full c00",      count_00, 40);
    chk("full c01",      count_01, 30);
    chk("full c10",      count_10, 20);
    chk("full c11",      count_11, 38);
    chk("full len",      window_len, 128);
    chk("full in_ready", in_ready, 0);
    chk("full busy",     busy, 0);

    // Gapped valid, all samples 11.
    do_ack();
    do_start();
    acc = 0;
    for (int t = 0; t < 2000 && acc < SL; t++) begin
      valid_in = 1'($urandom % 2); stream_a = 1'b1; stream_b = 1'b1;
      if (valid_in && in_ready) acc++;
      cycle();
      check_model("gap");
      if (acc < SL) chk("gap early close", counts_valid, 0);
    end
    idle_inputs();
    chk("gap accepted", acc, SL);
    chk("gap c11", count_11, 128);
    chk("gap c00", count_00, 0);
    chk("gap c01", count_01, 0);
    chk("gap c10", count_10, 0);

    // Back-to-back windows; second closes into FLUSH.
    do_ack();
    do_start();
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1; cycle(); check_model("b2b w1");
    end
    valid_in = 1'b0; end_window = 1'b1;
    cycle(); check_model("b2b w1 close");
    end_window = 1'b0;
    do_start();
    for (int i = 0; i < 5; i++) begin
      valid_in = 1'b1; stream_a = 1'b1; stream_b = 1'b0;
      end_window = (i == 4);
      cycle(); check_model("b2b w2");
    end
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      chk("flush in_ready", in_ready, 0);
      chk("flush busy",     busy, 1);
      chk("flush valid",    counts_valid, 1);
      chk("flush c00 held", count_00, 3);
      chk("flush c10 held", count_10, 0);
      chk("flush len held", window_len, 3);
      cycle(); check_model("flush wait");
    end
    counts_ack = 1'b1;
    cycle(); check_model("flush exit");
    counts_ack = 1'b0;
    chk("flush exit valid", counts_valid, 1);
    chk("flush exit c10",   count_10, 5);
    chk("flush exit c00",   count_00, 0);
    chk("flush exit len",   window_len, 5);
    chk("flush exit busy",  busy, 0);
    cycle(); check_model("hold");
    chk("hold valid", counts_valid, 1);
    do_ack();
    chk("ack clears valid", counts_valid, 0);

    // Reset mid-window after 64 samples.
    do_start();
    for (int i = 0; i < 64; i++) begin
      valid_in = 1'b1; stream_a = 1'($urandom); stream_b = 1'($urandom);
      cycle(); check_model("pre-reset");
    end
    idle_inputs();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("rst valid", counts_valid, 0);
    chk("rst ready", in_ready, 0);
    chk("rst busy",  busy, 0);
    chk("rst sum",   count_00 + count_01 + count_10 + count_11, 0);
    chk("rst len",   window_len, 0);
    cycle(); check_model("post-reset");
    chk("no valid after rst", counts_valid, 0);
    do_start();
    for (int i = 0; i < SL; i++) begin
      valid_in = 1'b1; stream_a = 1'($urandom); stream_b = 1'($urandom);
      cycle(); check_model("post-rst win");
    end
    idle_inputs();
    chk("post-rst len", window_len, 128);
    chk("post-rst sum", count_00 + count_01 + count_10 + count_11, 128);

    // Random traffic.
    for (int t = 0; t < 4000; t++) begin
      rst_n          = ($urandom % 500) != 0;
      start_compress = ($urandom % 8) == 0;
      valid_in       = ($urandom % 10) < 7;
      stream_a       = 1'($urandom);
      stream_b       = 1'($urandom);
      end_window     = ($urandom % 40) == 0;
      counts_ack     = ($urandom % 4) == 0;
      cycle();
      check_model("rand");
      chk("rand len=sum", window_len, count_00 + count_01 + count_10 + count_11);
    end
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
